// File: rtl/axis_complex_gain_mc_if.sv
// Packed multi-channel AXI-Stream bundle carrying I/Q items, I in the upper half.
interface axis_complex_gain_mc_if #(
  parameter int NUM_CH = 1,
  parameter int SAMP_W = 16
);
  logic [2*SAMP_W*NUM_CH-1:0] tdata;
  logic [NUM_CH-1:0]          tlast;
  logic [NUM_CH-1:0]          tvalid;
  logic [NUM_CH-1:0]          tready;

  modport master (output tdata, tlast, tvalid, input tready);
  modport slave  (input tdata, tlast, tvalid, output tready);
endinterface

// File: rtl/axis_complex_gain_mc.sv
// Per-channel complex gain on packed I/Q streams: 4 register levels, round-half-up,
// saturation, sticky clip flags, and gain updates latched only at packet starts.
module axis_complex_gain_mc #(
  parameter int NUM_CH    = 1,
  parameter int SAMP_W    = 16,
  parameter int GAIN_W    = 16,
  parameter int FRAC_BITS = 0,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_wr_stb,
  input  logic [CH_W-1:0]          cfg_wr_ch,
  input  logic signed [GAIN_W-1:0] cfg_wr_gain,
  input  logic [CH_W-1:0]          cfg_rd_ch,
  output logic signed [GAIN_W-1:0] cfg_rd_gain,
  input  logic [NUM_CH-1:0]        cfg_clr_clip,
  output logic [NUM_CH-1:0]        clip_flag,
  axis_complex_gain_mc_if.slave    s_axis,
  axis_complex_gain_mc_if.master   m_axis
);

  localparam int P_W = SAMP_W + GAIN_W;
  localparam int R_W = P_W + 1;
  localparam int FB1 = (FRAC_BITS > 0) ? FRAC_BITS - 1 : 0;
  localparam logic signed [GAIN_W-1:0] UNITY    = GAIN_W'(1) << FRAC_BITS;
  localparam logic signed [R_W-1:0]    RND_HALF = (FRAC_BITS > 0) ? R_W'(1) << FB1 : '0;
  localparam logic signed [R_W-1:0]    SMAX = {{(GAIN_W+2){1'b0}}, {(SAMP_W-1){1'b1}}};
  localparam logic signed [R_W-1:0]    SMIN = {{(GAIN_W+2){1'b1}}, {(SAMP_W-1){1'b0}}};

  // One extra bit of headroom so the rounding constant can never wrap the product.
  function automatic logic signed [R_W-1:0] rnd(input logic signed [P_W-1:0] p);
    return (R_W'(p) + RND_HALF) >>> FRAC_BITS;
  endfunction

  // Returns {saturated, value}.
  function automatic logic [SAMP_W:0] saturate(input logic signed [R_W-1:0] r);
    if (r > SMAX) return {1'b1, SMAX[SAMP_W-1:0]};
    if (r < SMIN) return {1'b1, SMIN[SAMP_W-1:0]};
    return {1'b0, r[SAMP_W-1:0]};
  endfunction

  logic [NUM_CH*GAIN_W-1:0] pend_flat;
  logic signed [GAIN_W-1:0] rd_next;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic signed [GAIN_W-1:0] pend_gain, act_gain, use_gain;
    logic                     sop, en, acc, wr_hit;
    logic [2*SAMP_W-1:0]      in_item;
    logic                     s1_vld, s1_last;
    logic signed [SAMP_W-1:0] s1_i, s1_q;
    logic signed [GAIN_W-1:0] s1_gain;
    logic                     s2_vld, s2_last;
    logic signed [P_W-1:0]    s2_pi, s2_pq;
    logic                     s3_vld, s3_last;
    logic signed [R_W-1:0]    s3_ri, s3_rq;
    logic [SAMP_W:0]          sat_i, sat_q;
    logic                     o_vld, o_last, o_sat, clip;
    logic [SAMP_W-1:0]        o_i, o_q;

    assign in_item  = s_axis.tdata[2*SAMP_W*c +: 2*SAMP_W];
    assign en       = !o_vld || m_axis.tready[c];
    assign acc      = s_axis.tvalid[c] && en && !rst;
    assign wr_hit   = cfg_wr_stb && (cfg_wr_ch == CH_W'(c));
    assign use_gain = sop ? pend_gain : act_gain;
    assign sat_i    = saturate(s3_ri);
    assign sat_q    = saturate(s3_rq);

    always_ff @(posedge clk) begin
      if (rst) begin
        pend_gain <= UNITY;
        act_gain  <= UNITY;
        sop       <= 1'b1;
        s1_vld    <= 1'b0;
        s1_last   <= 1'b0;
        s1_i      <= '0;
        s1_q      <= '0;
        s1_gain   <= '0;
        s2_vld    <= 1'b0;
        s2_last   <= 1'b0;
        s2_pi     <= '0;
        s2_pq     <= '0;
        s3_vld    <= 1'b0;
        s3_last   <= 1'b0;
        s3_ri     <= '0;
        s3_rq     <= '0;
        o_vld     <= 1'b0;
        o_last    <= 1'b0;
        o_sat     <= 1'b0;
        o_i       <= '0;
        o_q       <= '0;
        clip      <= 1'b0;
      end else begin
        // The sop beat samples pending before any same-cycle write lands.
        if (wr_hit) pend_gain <= cfg_wr_gain;
        if (acc) begin
          sop <= s_axis.tlast[c];
          if (sop) act_gain <= pend_gain;
        end
        if (en) begin
          s1_vld  <= acc;
          s1_last <= s_axis.tlast[c];
          s1_i    <= in_item[2*SAMP_W-1:SAMP_W];
          s1_q    <= in_item[SAMP_W-1:0];
          s1_gain <= use_gain;
          s2_vld  <= s1_vld;
          s2_last <= s1_last;
          s2_pi   <= P_W'(s1_i) * P_W'(s1_gain);
          s2_pq   <= P_W'(s1_q) * P_W'(s1_gain);
          s3_vld  <= s2_vld;
          s3_last <= s2_last;
          s3_ri   <= rnd(s2_pi);
          s3_rq   <= rnd(s2_pq);
          o_vld   <= s3_vld;
          o_last  <= s3_last;
          o_i     <= sat_i[SAMP_W-1:0];
          o_q     <= sat_q[SAMP_W-1:0];
          o_sat   <= sat_i[SAMP_W] | sat_q[SAMP_W];
        end
        if (o_vld && m_axis.tready[c] && o_sat) clip <= 1'b1;
        else if (cfg_clr_clip[c])               clip <= 1'b0;
      end
    end

    assign s_axis.tready[c]                       = en && !rst;
    assign m_axis.tvalid[c]                       = o_vld;
    assign m_axis.tlast[c]                        = o_last;
    assign m_axis.tdata[2*SAMP_W*c +: 2*SAMP_W]   = {o_i, o_q};
    assign clip_flag[c]                           = clip;
    assign pend_flat[c*GAIN_W +: GAIN_W]          = pend_gain;
  end

  always_comb begin
    rd_next = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (cfg_rd_ch == CH_W'(i)) rd_next = pend_flat[i*GAIN_W +: GAIN_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cfg_rd_gain <= '0;
    else     cfg_rd_gain <= rd_next;
  end

endmodule

// File: tb/tb_axis_complex_gain_mc.sv
// Scoreboard bench: dut_a (2 channels, integer gain) drives lanes 0/1, dut_b (1 channel,
// 8 fractional bits) drives lane 2; expectations are computed when beats are accepted.
module tb_axis_complex_gain_mc;

  typedef struct {
    logic [31:0] data;
    logic        last;
    int          cyc;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        a_wr_stb, a_wr_ch, a_rd_ch;
  logic [15:0] a_wr_gain, a_rd_gain;
  logic [1:0]  a_clr, a_clip;
  logic        b_wr_stb, b_wr_ch, b_rd_ch;
  logic [15:0] b_wr_gain, b_rd_gain;
  logic [0:0]  b_clr, b_clip;

  logic [31:0] in_d [3];
  logic [2:0]  in_v, in_l, mrdy, rdy, cuse;
  logic [31:0] cexp [3];
  logic [2:0]  out_v, out_l;
  logic [31:0] out_d [3];
  logic        chk_lat, stall_en;

  axis_complex_gain_mc_if #(.NUM_CH(2), .SAMP_W(16)) a_s ();
  axis_complex_gain_mc_if #(.NUM_CH(2), .SAMP_W(16)) a_m ();
  axis_complex_gain_mc_if #(.NUM_CH(1), .SAMP_W(16)) b_s ();
  axis_complex_gain_mc_if #(.NUM_CH(1), .SAMP_W(16)) b_m ();

  assign a_s.tdata  = {in_d[1], in_d[0]};
  assign a_s.tvalid = in_v[1:0];
  assign a_s.tlast  = in_l[1:0];
  assign b_s.tdata  = in_d[2];
  assign b_s.tvalid = in_v[2];
  assign b_s.tlast  = in_l[2];
  assign a_m.tready = mrdy[1:0];
  assign b_m.tready = mrdy[2];
  assign rdy        = {b_s.tready, a_s.tready};
  assign out_v      = {b_m.tvalid, a_m.tvalid};
  assign out_l      = {b_m.tlast, a_m.tlast};
  assign out_d[0]   = a_m.tdata[31:0];
  assign out_d[1]   = a_m.tdata[63:32];
  assign out_d[2]   = b_m.tdata;

  axis_complex_gain_mc #(.NUM_CH(2), .SAMP_W(16), .GAIN_W(16), .FRAC_BITS(0)) dut_a (
    .clk(clk), .rst(rst),
    .cfg_wr_stb(a_wr_stb), .cfg_wr_ch(a_wr_ch), .cfg_wr_gain(a_wr_gain),
    .cfg_rd_ch(a_rd_ch), .cfg_rd_gain(a_rd_gain),
    .cfg_clr_clip(a_clr), .clip_flag(a_clip),
    .s_axis(a_s), .m_axis(a_m)
  );

  axis_complex_gain_mc #(.NUM_CH(1), .SAMP_W(16), .GAIN_W(16), .FRAC_BITS(8)) dut_b (
    .clk(clk), .rst(rst),
    .cfg_wr_stb(b_wr_stb), .cfg_wr_ch(b_wr_ch), .cfg_wr_gain(b_wr_gain),
    .cfg_rd_ch(b_rd_ch), .cfg_rd_gain(b_rd_gain),
    .cfg_clr_clip(b_clr), .clip_flag(b_clip),
    .s_axis(b_s), .m_axis(b_m)
  );

  ent_t        sb [3][$];
  logic [15:0] m_pend [3];
  logic [15:0] m_act [3];
  logic        m_sop [3];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] rs();
    int t;
    t = int'($urandom_range(0, 510)) - 255;
    return 16'(t);
  endfunction

  function automatic logic [31:0] exp_item(input logic [31:0] x, input logic [15:0] g, input int frac);
    logic [31:0] r;
    logic [15:0] h;
    longint      p;
    r = '0;
    for (int k = 0; k < 2; k++) begin
      h = (k == 0) ? x[15:0] : x[31:16];
      p = longint'($signed(h)) * longint'($signed(g));
      if (frac > 0) p = (p + (longint'(1) <<< (frac - 1))) >>> frac;
      if (p > 32767) p = 32767;
      else if (p < -32768) p = -32768;
      if (k == 0) r[15:0] = 16'(p);
      else        r[31:16] = 16'(p);
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int l = 0; l < 3; l++) begin
      m_pend[l] = (l == 2) ? 16'h0100 : 16'h0001;
      m_act[l]  = m_pend[l];
      m_sop[l]  = 1'b1;
      sb[l].delete();
    end
  endtask

  task automatic step(input int wlane, input logic [15:0] wg, output logic [2:0] acc);
    logic [15:0] g;
    ent_t        e;
    if (stall_en) mrdy[0] = ($urandom_range(0, 3) != 0);
    if (wlane == 0 || wlane == 1) begin
      a_wr_stb = 1'b1; a_wr_ch = wlane[0]; a_wr_gain = wg;
    end else if (wlane == 2) begin
      b_wr_stb = 1'b1; b_wr_ch = 1'b0; b_wr_gain = wg;
    end
    @(negedge clk);
    acc = in_v & rdy;
    for (int l = 0; l < 3; l++) begin
      if (acc[l]) begin
        g = m_sop[l] ? m_pend[l] : m_act[l];
        if (m_sop[l]) m_act[l] = m_pend[l];
        m_sop[l] = in_l[l];
        e.data = cuse[l] ? cexp[l] : exp_item(in_d[l], g, (l == 2) ? 8 : 0);
        e.last = in_l[l];
        e.cyc  = cyc;
        sb[l].push_back(e);
      end
    end
    if (wlane >= 0 && wlane < 3) m_pend[wlane] = wg;
    @(posedge clk); #1;
    a_wr_stb = 1'b0;
    b_wr_stb = 1'b0;
  endtask

  task automatic xfer(input logic [2:0] mask, input int wlane, input logic [15:0] wg);
    logic [2:0] left, acc;
    int n;
    left = mask;
    n = 0;
    in_v = mask;
    while (left != 0 && n < 200) begin
      step((n == 0) ? wlane : -1, wg, acc);
      left = left & ~acc;
      in_v = left;
      n++;
    end
    chk("xfer_done", 64'(left), 64'd0);
  endtask

  task automatic wr(input int lane, input logic [15:0] g);
    logic [2:0] acc;
    in_v = '0;
    step(lane, g, acc);
  endtask

  task automatic idle(input int n);
    logic [2:0] acc;
    in_v = '0;
    repeat (n) step(-1, '0, acc);
  endtask

  always @(negedge clk) begin
    for (int l = 0; l < 3; l++) begin
      if (out_v[l] && mrdy[l]) begin
        ent_t e;
        if (sb[l].size() == 0) begin
          chk($sformatf("unexpected_out_lane%0d", l), 64'd1, 64'd0);
        end else begin
          e = sb[l].pop_front();
          chk($sformatf("data_lane%0d", l), 64'(out_d[l]), 64'(e.data));
          chk($sformatf("last_lane%0d", l), 64'(out_l[l]), 64'(e.last));
          if (chk_lat) chk($sformatf("latency_lane%0d", l), 64'(cyc - e.cyc), 64'd4);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    a_wr_stb = 1'b0; a_wr_ch = 1'b0; a_wr_gain = '0; a_rd_ch = 1'b0; a_clr = '0;
    b_wr_stb = 1'b0; b_wr_ch = 1'b0; b_wr_gain = '0; b_rd_ch = 1'b0; b_clr = '0;
    for (int l = 0; l < 3; l++) begin
      in_d[l] = '0;
      cexp[l] = '0;
    end
    in_v = '0; in_l = '0; mrdy = 3'b111; cuse = '0;
    chk_lat = 1'b0; stall_en = 1'b0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", 64'(a_m.tvalid), 64'd0);
    chk("rst_tdata", 64'(a_m.tdata), 64'd0);
    chk("rst_tlast", 64'(a_m.tlast), 64'd0);
    chk("rst_tready", 64'(a_s.tready), 64'd0);
    chk("rst_clip", 64'(a_clip), 64'd0);
    chk("rst_rd_gain", 64'(a_rd_gain), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("tready_after_rst", 64'(a_s.tready), 64'd3);
    @(negedge clk);
    chk("rd_unity_a", 64'(a_rd_gain), 64'h0001);
    chk("rd_unity_b", 64'(b_rd_gain), 64'h0100);
    @(posedge clk); #1;

    // Unity gain, both channels streaming, latency checked
    chk_lat = 1'b1;
    for (int i = 0; i < 64; i++) begin
      in_d[0] = {rs(), rs()};
      in_d[1] = {rs(), rs()};
      in_l[0] = (i == 63);
      in_l[1] = (i == 63);
      xfer(3'b011, -1, '0);
    end
    idle(6);
    chk_lat = 1'b0;
    chk("clip_unity", 64'(a_clip), 64'd0);

    // Gain -1 with the -32768 saturation case
    wr(0, 16'hFFFF);
    cuse[0] = 1'b1;
    in_d[0] = 32'h0005FFFB; cexp[0] = 32'hFFFB0005; in_l[0] = 1'b0;
    xfer(3'b001, -1, '0);
    in_d[0] = 32'h80007FFF; cexp[0] = 32'h7FFF8001; in_l[0] = 1'b1;
    xfer(3'b001, -1, '0);
    cuse[0] = 1'b0;
    idle(8);
    chk("clip_set", 64'(a_clip), 64'd1);
    chk("rd_gain_ch0", 64'(a_rd_gain), 64'hFFFF);
    a_clr = 2'b01;
    idle(1);
    a_clr = 2'b00;
    chk("clip_cleared", 64'(a_clip), 64'd0);

    // Gain 256 saturates both ways; gain 37 exact
    wr(1, 16'd256);
    cuse[1] = 1'b1;
    in_d[1] = 32'h00C8FF38; cexp[1] = 32'h7FFF8000; in_l[1] = 1'b1;
    xfer(3'b010, -1, '0);
    wr(1, 16'd37);
    in_d[1] = 32'hFFF90064; cexp[1] = 32'hFEFD0E74; in_l[1] = 1'b1;
    xfer(3'b010, -1, '0);
    cuse[1] = 1'b0;
    a_rd_ch = 1'b1;
    idle(8);
    chk("rd_gain_ch1", 64'(a_rd_gain), 64'h0025);
    chk("clip_ch1_only", 64'(a_clip), 64'd2);

    // Fractional gain 0.5 with round-half-up
    wr(2, 16'h0080);
    cuse[2] = 1'b1;
    in_d[2] = 32'h00030000; cexp[2] = 32'h00020000; in_l[2] = 1'b0;
    xfer(3'b100, -1, '0);
    in_d[2] = 32'hFFFD0000; cexp[2] = 32'hFFFF0000; in_l[2] = 1'b0;
    xfer(3'b100, -1, '0);
    in_d[2] = 32'h00010000; cexp[2] = 32'h00010000; in_l[2] = 1'b1;
    xfer(3'b100, -1, '0);
    cuse[2] = 1'b0;

    // Out-of-range channel: read returns 0, write ignored
    b_rd_ch = 1'b1;
    idle(2);
    chk("rd_out_of_range", 64'(b_rd_gain), 64'd0);
    b_wr_stb = 1'b1; b_wr_ch = 1'b1; b_wr_gain = 16'h1234;
    idle(1);
    b_rd_ch = 1'b0;
    idle(2);
    chk("wr_out_of_range", 64'(b_rd_gain), 64'h0080);

    // Mid-packet write deferred; write at sop applies one packet later
    wr(0, 16'd3);
    for (int i = 0; i < 64; i++) begin
      in_d[0] = {rs(), rs()};
      in_l[0] = (i == 63);
      xfer(3'b001, (i == 10) ? 0 : -1, 16'd5);
    end
    for (int i = 0; i < 4; i++) begin
      in_d[0] = {rs(), rs()};
      in_l[0] = (i == 3);
      xfer(3'b001, (i == 0) ? 0 : -1, 16'd7);
    end
    for (int i = 0; i < 4; i++) begin
      in_d[0] = {rs(), rs()};
      in_l[0] = (i == 3);
      xfer(3'b001, -1, '0);
    end
    idle(6);

    // Random backpressure on channel 0, then reset mid-packet
    wr(0, 16'd2);
    stall_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_d[0] = {rs(), rs()};
      in_d[1] = {rs(), rs()};
      in_l[0] = 1'b0;
      in_l[1] = 1'b0;
      xfer(3'b011, -1, '0);
    end
    rst = 1'b1;
    in_v = '0;
    @(negedge clk);
    chk("tready_in_rst", 64'(a_s.tready), 64'd0);
    @(posedge clk); #1;
    model_reset();
    stall_en = 1'b0;
    mrdy = 3'b111;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("tvalid_after_rst", 64'(a_m.tvalid), 64'd0);
    chk("tready_after_rst2", 64'(a_s.tready), 64'd3);
    @(posedge clk); #1;
    wr(0, 16'hFFFE);
    for (int i = 0; i < 4; i++) begin
      in_d[0] = {rs(), rs()};
      in_l[0] = (i == 3);
      xfer(3'b001, -1, '0);
    end
    idle(10);
    chk("sb_drained", 64'(sb[0].size() + sb[1].size() + sb[2].size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_complex_gain_mc.md
# axis_complex_gain_mc

- Multi-channel, pipelined complex-gain datapath core.
- Each channel scales packed I/Q samples on an AXI-Stream by a signed per-channel gain, with optional fixed-point fraction, rounding and saturation.
- Gain changes take effect only on packet boundaries, so no packet is ever scaled by two different gains.
- Sits between the NoC shell's per-port data streams and the register interface of the next-generation gain block.

## Interface
Parameters:
- NUM_CH, 1: number of independent channels.
- SAMP_W, 16: bits per I or Q component; an item is 2*SAMP_W bits, I in the upper half.
- GAIN_W, 16: signed gain width.
- FRAC_BITS, 0: fractional bits of the gain; 0 gives integer gain.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- cfg_wr_stb  in  1  gain write strobe.
- cfg_wr_ch  in  $clog2(NUM_CH) (min 1)  channel to write.
- cfg_wr_gain  in  GAIN_W  signed gain value.
- cfg_rd_ch  in  $clog2(NUM_CH) (min 1)  channel to read back.
- cfg_rd_gain  out  GAIN_W  pending gain of cfg_rd_ch, registered.
- cfg_clr_clip  in  NUM_CH  per-channel clip-flag clear pulse.
- clip_flag  out  NUM_CH  sticky saturation indicator.
- s_axis_tdata  in  2*SAMP_W*NUM_CH  input items, channel c at [2*SAMP_W*c +: 2*SAMP_W].
- s_axis_tlast  in  NUM_CH  end of packet.
- s_axis_tvalid  in  NUM_CH  input valid.
- s_axis_tready  out  NUM_CH  input ready.
- m_axis_tdata  out  2*SAMP_W*NUM_CH  scaled items.
- m_axis_tlast  out  NUM_CH  end of packet, delayed with its data.
- m_axis_tvalid  out  NUM_CH  output valid.
- m_axis_tready  in  NUM_CH  output ready.

## Operation
Gain registers (per channel):
- Each channel holds a pending gain and an active gain; both reset to unity, 1<<FRAC_BITS.
- cfg_wr_stb writes cfg_wr_gain into the pending gain of cfg_wr_ch.
- A per-channel sop flag is set by reset and by an accepted beat with tlast=1. It is cleared by an accepted beat with tlast=0.
- When a beat is accepted with sop=1, that beat uses the pending gain, and the pending gain is copied to active.
- All other beats use the active gain.
- A write in the same cycle as an sop acceptance is not seen by that packet; it applies from the next packet.

Arithmetic (independently for I and Q):
- p = signed(x) * signed(g), width SAMP_W+GAIN_W.
- If FRAC_BITS>0: p = (p + 2^(FRAC_BITS-1)) >>> FRAC_BITS, arithmetic shift, round-half-up.
- Saturate to [-2^(SAMP_W-1), 2^(SAMP_W-1)-1].
- With FRAC_BITS=0 the result is the exact product, clipped.

Clip flag:
- clip_flag[c] sets when an output beat of channel c leaves the pipeline (m_axis_tvalid && m_axis_tready) with either component saturated.
- cfg_clr_clip[c] clears it. If set and clear occur in the same cycle, set wins.

Readback:
- cfg_rd_gain <= pending gain of cfg_rd_ch, one-cycle latency.
- Out-of-range cfg_rd_ch or cfg_wr_ch: reads return 0, writes are ignored.

## Timing
- Three-stage pipeline per channel: stage 1 registers the input and selects the gain; stage 2 multiplies; stage 3 rounds, shifts and saturates. Outputs are registered.
- Latency: a beat accepted at edge N appears on m_axis_tvalid after edge N+3 when there is no backpressure.
- Flow control: per-channel enable en = !m_axis_tvalid || m_axis_tready. s_axis_tready = en. The whole pipeline holds when en=0.
- Throughput is one beat per cycle per channel under continuous ready.
- tdata and tlast stay stable while tvalid=1 and tready=0.
- Channels are fully independent; backpressure on one channel never stalls another.
- Reset values: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, s_axis_tready=0 during rst (then 1 on the first cycle after), clip_flag=0, cfg_rd_gain=0, sop=1, gains unity.
- Reset mid-packet discards all in-flight beats. The next accepted beat is treated as sop.

## Test plan
- Unity gain, NUM_CH=2, 64 random items in [-255,255] per channel -> outputs bit-identical to inputs, latency 3 cycles, clip_flag=0.
- Gain -1 on items 0x0005FFFB and 0x80007FFF -> 0xFFFB0005 and 0x7FFF8001, clip_flag set by the saturated 0x8000 case; cfg_clr_clip then clears it.
- Gain 256 on I=200, Q=-200 -> I=0x7FFF, Q=0x8000. Gain 37 on I=-7, Q=100 -> -259, 3700.
- FRAC_BITS=8, gain 0x0080 (0.5): I=3 -> 2, I=-3 -> -1, I=1 -> 1 (round-half-up).
- Gain write mid-packet (beat 10 of 64) -> whole packet uses the old gain and the next packet uses the new one; a write coinciding with an sop acceptance applies one packet later.
- 25% random m_axis_tready stall plus rst asserted mid-packet -> no data loss or duplication before reset, tvalid=0 the cycle after reset, first post-reset beat uses the pending gain.
